// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the arbitrated binary-to-BCD converter.
package bcd_arb_pkg;

  localparam int BCD_W = 10;
  localparam int BIN_W = 8;
  localparam int STEPS = 6;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Subtraction weights in step order: two hundreds bits, then four tens bits.
  localparam logic [BIN_W-1:0] W [0:STEPS-1] = '{8'd200, 8'd100, 8'd80, 8'd40, 8'd20, 8'd10};

endpackage

// File: rtl/bcd_rr_pick.sv
// Combinational circular-priority picker; first valid index after ptr_i wins.
// Optional BCD_ARB_FIXED_PRI_EN selects lowest-index-wins and ignores ptr_i.
module bcd_rr_pick
  import bcd_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            any_o,
  output logic [ID_W-1:0] grant_o
);

  int unsigned idx;

`ifdef BCD_ARB_FIXED_PRI_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef BCD_ARB_FIXED_PRI_EN
      idx = NREQ - 1 - k;
`else
      idx = (int'(ptr_i) + NREQ - k) % NREQ;
`endif
      if (valid_i[ID_W'(idx)]) begin
        any_o   = 1'b1;
        grant_o = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// One sequential 8-bit binary-to-BCD engine shared by NREQ requesters.
// Define BCD_ARB_FIXED_PRI_EN for fixed (lowest-index) priority instead of round-robin.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [BIN_W*NREQ-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BCD_W-1:0]      out_bcd,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy
);

  state_t             state_q;
  logic [BIN_W-1:0]   rem_q;
  logic [STEPS-1:0]   bits_q;
  logic [2:0]         step_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic               out_valid_q;
  logic [BCD_W-1:0]   out_bcd_q;

  logic               pick_any;
  logic [ID_W-1:0]    pick_grant;
  logic [BIN_W-1:0]   sel_bin;
  logic [BIN_W-1:0]   weight;
  logic               take;
  logic [BIN_W-1:0]   rem_d;
  logic [STEPS-1:0]   bits_d;

  bcd_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .any_o   (pick_any),
    .grant_o (pick_grant)
  );

  assign sel_bin = req_bin[int'(pick_grant)*BIN_W +: BIN_W];

  // One restoring compare-subtract step; result bits shift in MSB first.
  always_comb begin
    weight = W[step_q];
    take   = (rem_q >= weight);
    rem_d  = take ? (rem_q - weight) : rem_q;
    bits_d = {bits_q[STEPS-2:0], take};
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == IDLE) && pick_any && (pick_grant == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      bits_q      <= '0;
      step_q      <= '0;
      id_q        <= '0;
      rr_ptr_q    <= ID_W'(NREQ - 1);
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            rem_q   <= sel_bin;
            id_q    <= pick_grant;
            step_q  <= '0;
            bits_q  <= '0;
            state_q <= CONV;
`ifndef BCD_ARB_FIXED_PRI_EN
            rr_ptr_q <= pick_grant;
`endif
          end
        end
        CONV: begin
          rem_q  <= rem_d;
          bits_q <= bits_d;
          step_q <= step_q + 3'd1;
          if (step_q == 3'(STEPS - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_bcd_q   <= {bits_d, rem_d[3:0]};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of arbitration and decimal conversion.
module tb_bcd_conv_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_bin;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [9:0]        out_bcd;
  logic [ID_W-1:0]   out_id;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_id    (out_id),
    .busy      (busy)
  );

  function automatic logic [9:0] exp_bcd(input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    return {h[1:0], t[3:0], u[3:0]};
  endfunction

  function automatic int exp_pick(input logic [NREQ-1:0] v, input int ptr);
`ifdef BCD_ARB_FIXED_PRI_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        if (r >= 0) return -2;
        r = i;
      end
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int r, input logic [7:0] v);
    req_bin[r*8 +: 8] = v;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Stimulus only: issue one request on requester r and collect its result.
  task automatic convert(input int r, input logic [7:0] v,
                         output logic [9:0] bcd, output int id, output int lat, output bit ok);
    int n;
    ok = 1'b1;
    bcd = '0;
    id = -1;
    lat = -1;
    req_valid = '0;
    req_valid[r] = 1'b1;
    set_bin(r, v);
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 40) begin
      tick();
      #1;
      n++;
    end
    if (!req_ready[r]) begin
      ok = 1'b0;
      req_valid = '0;
      tick();
      return;
    end
    tick();
    req_valid[r] = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) ok = 1'b0;
    lat = n;
    bcd = out_bcd;
    id = int'(out_id);
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0;
    req_bin = '0;
    out_ready = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_bcd !== 10'h000) begin errors++; $display("FAIL reset_out_bcd got %h want 000", out_bcd); end
    checks++; if (out_id !== '0) begin errors++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int n;
    req_valid = 4'b0001;
    set_bin(0, 8'd255);
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL single_ready_drop got %b want 0000", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL single_latency got %0d want 6", n); end
    checks++; if (out_bcd !== 10'h255) begin errors++; $display("FAIL single_bcd got %h want 255", out_bcd); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", out_id); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release got valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_sweep;
    logic [9:0] bcd;
    int id, lat;
    bit ok;
    for (int v = 0; v < 256; v++) begin
      convert(1, 8'(v), bcd, id, lat, ok);
      checks++;
      if (!ok || bcd !== exp_bcd(v) || id != 1) begin
        errors++;
        $display("FAIL sweep_%0d got bcd=%h id=%0d ok=%0d want bcd=%h id=1", v, bcd, id, ok, exp_bcd(v));
      end
      checks++; if (lat != 6) begin errors++; $display("FAIL sweep_latency_%0d got %0d want 6", v, lat); end
    end
  endtask

  task automatic test_all4;
    int gq[$], gc[$], rid[$];
    logic [9:0] rbcd[$];
    logic [9:0] want_bcd[NREQ];
    int pending, g;
    want_bcd[0] = 10'h010; want_bcd[1] = 10'h020; want_bcd[2] = 10'h030; want_bcd[3] = 10'h040;
    pulse_reset();
    set_bin(0, 8'd10); set_bin(1, 8'd20); set_bin(2, 8'd30); set_bin(3, 8'd40);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    pending = -1;
    for (int c = 0; c < 60; c++) begin
      if (pending >= 0) begin req_valid[pending] = 1'b0; pending = -1; end
      #1;
      if (out_valid) begin rid.push_back(int'(out_id)); rbcd.push_back(out_bcd); end
      if (req_ready != '0) begin
        g = oh_idx(req_ready);
        gq.push_back(g);
        gc.push_back(c);
        pending = (g >= 0) ? g : -1;
      end
      tick();
    end
    checks++; if (gq.size() != 4) begin errors++; $display("FAIL all4_grants got %0d want 4", gq.size()); end
    checks++; if (rid.size() != 4) begin errors++; $display("FAIL all4_results got %0d want 4", rid.size()); end
    for (int i = 0; i < 4 && i < gq.size() && i < rid.size(); i++) begin
      checks++; if (gq[i] != i) begin errors++; $display("FAIL all4_order_%0d got %0d want %0d", i, gq[i], i); end
      checks++; if (rid[i] != i || rbcd[i] !== want_bcd[i]) begin errors++; $display("FAIL all4_result_%0d got id=%0d bcd=%h want id=%0d bcd=%h", i, rid[i], rbcd[i], i, want_bcd[i]); end
      if (i > 0) begin
        checks++; if (gc[i] - gc[i-1] != 8) begin errors++; $display("FAIL all4_period_%0d got %0d want 8", i, gc[i] - gc[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] v;
    int n;
    v = 8'($urandom_range(0, 255));
    req_valid = 4'b0100;
    set_bin(2, v);
    out_ready = 1'b0;
    #1;
    n = 0;
    while (!req_ready[2] && n < 40) begin tick(); #1; n++; end
    checks++; if (!req_ready[2]) begin errors++; $display("FAIL bp_grant got %b want x1xx", req_ready); end
    tick();
    req_valid = 4'b1011;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_valid got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_bcd !== exp_bcd(int'(v)) || out_id !== 2'd2 || req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid=%b bcd=%h id=%0d ready=%b busy=%b want 1 %h 2 0000 1",
                 i, out_valid, out_bcd, out_id, req_ready, busy, exp_bcd(int'(v)));
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    req_valid = '0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_abort;
    logic [9:0] bcd;
    int id, lat, n, seen;
    bit ok;
    req_valid = 4'b1000;
    set_bin(3, 8'd199);
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready[3] && n < 40) begin tick(); #1; n++; end
    checks++; if (!req_ready[3]) begin errors++; $display("FAIL abort_grant got %b want 1xxx", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_bcd !== '0 || out_id !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL abort_clear got valid=%b bcd=%h id=%0d busy=%b ready=%b want all 0",
               out_valid, out_bcd, out_id, busy, req_ready);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
    convert(3, 8'd7, bcd, id, lat, ok);
    checks++; if (!ok || bcd !== 10'h007 || id != 3) begin errors++; $display("FAIL abort_after got bcd=%h id=%0d ok=%0d want 007 3", bcd, id, ok); end
  endtask

  task automatic test_back_to_back;
    int ac[$];
    logic [9:0] res[$];
    int n;
    req_valid = 4'b0001;
    set_bin(0, 8'd123);
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid) res.push_back(out_bcd);
      if (req_ready[0]) ac.push_back(c);
      tick();
    end
    req_valid = '0;
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (busy) begin errors++; $display("FAIL b2b_drain got busy=1 want 0"); end
    checks++; if (ac.size() < 4) begin errors++; $display("FAIL b2b_accepts got %0d want >=4", ac.size()); end
    for (int i = 1; i < ac.size(); i++) begin
      checks++; if (ac[i] - ac[i-1] != 8) begin errors++; $display("FAIL b2b_period_%0d got %0d want 8", i, ac[i] - ac[i-1]); end
    end
    for (int i = 0; i < res.size(); i++) begin
      checks++; if (res[i] !== 10'h123) begin errors++; $display("FAIL b2b_result_%0d got %h want 123", i, res[i]); end
    end
  endtask

  task automatic test_two_contenders;
    int ids[$];
    int ptr, g, n;
    pulse_reset();
    set_bin(0, 8'd42);
    set_bin(2, 8'd87);
    req_valid = 4'b0101;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready != '0) ids.push_back(oh_idx(req_ready));
      tick();
    end
    req_valid = '0;
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (ids.size() < 5) begin errors++; $display("FAIL contend_grants got %0d want >=5", ids.size()); end
    ptr = NREQ - 1;
    for (int i = 0; i < ids.size(); i++) begin
      g = exp_pick(4'b0101, ptr);
      ptr = g;
      checks++; if (ids[i] != g) begin errors++; $display("FAIL contend_order_%0d got %0d want %0d", i, ids[i], g); end
    end
  endtask

  task automatic test_random;
    logic [7:0] vals[NREQ];
    int eq_id[$];
    logic [9:0] eq_bcd[$];
    int mdl_ptr, mdl_wait, pending, g, exp_id, n;
    bit mdl_busy, release_q;
    logic [NREQ-1:0] exp_rdy;
    logic [9:0] exp_b;
    pulse_reset();
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) vals[i] = '0;
    mdl_ptr = NREQ - 1;
    mdl_busy = 1'b0;
    mdl_wait = 0;
    release_q = 1'b0;
    pending = -1;
    for (int c = 0; c < 1500; c++) begin
      if (pending >= 0) begin req_valid[pending] = 1'b0; pending = -1; end
      if (release_q) begin mdl_busy = 1'b0; release_q = 1'b0; end
      else if (mdl_busy && mdl_wait > 0) mdl_wait--;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          vals[i] = 8'($urandom);
          set_bin(i, vals[i]);
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (!mdl_busy) begin
        g = exp_pick(req_valid, mdl_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready_c%0d got %b want %b", c, req_ready, exp_rdy); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_idle_c%0d got valid=%b busy=%b want 0 0", c, out_valid, busy); end
        if (g >= 0) begin
          mdl_busy = 1'b1;
          mdl_wait = 1 + 6;
          mdl_ptr = g;
          eq_id.push_back(g);
          eq_bcd.push_back(exp_bcd(int'(vals[g])));
          pending = g;
        end
      end else begin
        checks++;
        if (req_ready !== '0 || busy !== 1'b1 || out_valid !== (mdl_wait == 0)) begin
          errors++;
          $display("FAIL rand_busy_c%0d got ready=%b busy=%b valid=%b want 0000 1 %b",
                   c, req_ready, busy, out_valid, (mdl_wait == 0));
        end
        if (mdl_wait == 0 && out_ready && eq_id.size() > 0) begin
          exp_id = eq_id.pop_front();
          exp_b = eq_bcd.pop_front();
          checks++;
          if (out_id !== ID_W'(exp_id) || out_bcd !== exp_b) begin
            errors++;
            $display("FAIL rand_result_c%0d got id=%0d bcd=%h want id=%0d bcd=%h", c, out_id, out_bcd, exp_id, exp_b);
          end
          release_q = 1'b1;
        end
      end
      tick();
    end
    req_valid = '0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (busy) begin errors++; $display("FAIL rand_drain got busy=1 want 0"); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_all4();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_two_contenders();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
